// File: rtl/seg7_scan_mux.sv
// Multiplexed common-anode 7-segment scanner with refresh prescaler, blank gap,
// per-digit decimal point and blink, and frame-synchronous input shadowing.
module seg7_scan_mux #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DIV          = 50000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [5*NUM_DIGITS-1:0] digit_codes,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int unsigned CW = 5;
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [6:0]  SEG_OFF = 7'b1111111;

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [FW-1:0]         fcnt_q, fcnt_d;
  logic                  phase_q, phase_d;
  logic [CW-1:0]         sh_code_q [NUM_DIGITS];
  logic [CW-1:0]         sh_code_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0] sh_blink_q, sh_blink_d;
  logic [6:0]            seg_d;
  logic                  dp_d;
  logic [NUM_DIGITS-1:0] an_d;
  logic                  tick_d;
  logic                  slot_end;
  logic                  last_digit;
  logic                  boundary;
  logic                  lit;

  // Active-low {a..g} pattern for each character code.
  function automatic logic [6:0] decode(input logic [CW-1:0] code);
    logic [6:0] s;
    s = SEG_OFF;
    case (code)
      5'd0:  s = 7'b0000001;
      5'd1:  s = 7'b1001111;
      5'd2:  s = 7'b0010010;
      5'd3:  s = 7'b0000110;
      5'd4:  s = 7'b1001100;
      5'd5:  s = 7'b0100100;
      5'd6:  s = 7'b0100000;
      5'd7:  s = 7'b0001111;
      5'd8:  s = 7'b0000000;
      5'd9:  s = 7'b0000100;
      5'd10: s = 7'b0001000;
      5'd11: s = 7'b1100000;
      5'd12: s = 7'b0110001;
      5'd13: s = 7'b1000010;
      5'd14: s = 7'b0110000;
      5'd15: s = 7'b0111000;
      5'd16: s = 7'b1110001;
      5'd17: s = 7'b1001000;
      5'd18: s = 7'b0011000;
      5'd19: s = 7'b1111110;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  // Scan sequencing, frame/blink counting and shadow capture.
  always_comb begin
    presc_d    = presc_q;
    idx_d      = idx_q;
    fcnt_d     = fcnt_q;
    phase_d    = phase_q;
    sh_code_d  = sh_code_q;
    sh_dp_d    = sh_dp_q;
    sh_blink_d = sh_blink_q;

    slot_end   = (presc_q == PW'(DIV - 1));
    last_digit = (idx_q == IW'(NUM_DIGITS - 1));
    boundary   = enable && slot_end && last_digit;

    if (!enable || boundary) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        sh_code_d[i] = digit_codes[CW*i +: CW];
      end
      sh_dp_d    = dp_in;
      sh_blink_d = blink_mask;
    end

    if (!enable) begin
      presc_d = '0;
      idx_d   = '0;
      fcnt_d  = '0;
      phase_d = 1'b0;
    end else begin
      presc_d = slot_end ? '0 : presc_q + PW'(1);
      if (slot_end) begin
        idx_d = last_digit ? '0 : idx_q + IW'(1);
      end
      if (boundary) begin
        if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
          fcnt_d  = '0;
          phase_d = ~phase_q;
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end
    end
  end

  // Output image for the current slot; registered below for one-cycle latency.
  always_comb begin
    seg_d  = SEG_OFF;
    dp_d   = 1'b1;
    an_d   = '1;
    tick_d = boundary;
    lit    = enable && (presc_q >= PW'(BLANK_CYCLES)) && !(phase_q && sh_blink_q[idx_q]);
    if (lit) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = decode(sh_code_q[idx_q]);
      dp_d  = ~sh_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      idx_q      <= '0;
      fcnt_q     <= '0;
      phase_q    <= 1'b0;
      sh_code_q  <= '{default: '1};
      sh_dp_q    <= '0;
      sh_blink_q <= '0;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      fcnt_q     <= fcnt_d;
      phase_q    <= phase_d;
      sh_code_q  <= sh_code_d;
      sh_dp_q    <= sh_dp_d;
      sh_blink_q <= sh_blink_d;
      seg        <= seg_d;
      dp         <= dp_d;
      an         <= an_d;
      frame_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed, table-driven bench for seg7_scan_mux with 4 digits, 8-cycle slots,
// 2-cycle blank gap and 2-frame blink half-period.
module tb_seg7_scan_mux;

  localparam int unsigned N  = 4;
  localparam int unsigned FR = 32;

  logic           clk;
  logic           rst_n;
  logic           enable;
  logic [5*N-1:0] digit_codes;
  logic [N-1:0]   dp_in;
  logic [N-1:0]   blink_mask;
  logic [6:0]     seg;
  logic           dp;
  logic [N-1:0]   an;
  logic           frame_tick;

  int n_assert = 0;
  int n_fail   = 0;

  seg7_scan_mux #(
    .NUM_DIGITS(4), .DIV(8), .BLANK_CYCLES(2), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digit_codes(digit_codes),
    .dp_in(dp_in), .blink_mask(blink_mask), .seg(seg), .dp(dp), .an(an),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [19:0] codes;
    logic [3:0]  dpi;
    logic [27:0] eseg;  // {d3,d2,d1,d0} expected segment patterns
    logic [3:0]  edp;   // expected dp pin per digit while lit
  } vec_t;

  localparam logic [12:0] DARK = {4'b1111, 7'b1111111, 1'b1, 1'b0};
  localparam logic [27:0] E_BLANK = {4{7'b1111111}};
  localparam logic [27:0] E_3210  = {7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001};
  localparam logic [27:0] E_9218  = {7'b0000100, 7'b0010010, 7'b1001111, 7'b0000000};
  localparam logic [27:0] E_7654  = {7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100};

  task automatic check(input string name, input logic [12:0] exp);
    logic [12:0] act;
    act = {an, seg, dp, frame_tick};
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got an=%b seg=%b dp=%b tick=%b, want an=%b seg=%b dp=%b tick=%b",
               name, act[12:9], act[8:2], act[1], act[0], exp[12:9], exp[8:2], exp[1], exp[0]);
    end
  endtask

  // Positions j0..j1 of a frame, j=1 being the first edge after the frame start.
  task automatic check_range(input int j0, input int j1, input logic [27:0] eseg,
                             input logic [3:0] edp, input logic [3:0] vis, input string name);
    int s, p;
    logic [12:0] e;
    for (int j = j0; j <= j1; j++) begin
      @(negedge clk);
      s = (j - 1) / 8;
      p = (j - 1) % 8;
      if (p < 2 || !vis[s]) e = DARK;
      else e = {~(4'b0001 << s), eseg[7*s +: 7], edp[s], 1'b0};
      if (j == FR) e[0] = 1'b1;
      check($sformatf("%s j=%0d", name, j), e);
    end
  endtask

  task automatic wait_tick(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 100);
    n_assert++;
    if (frame_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: frame_tick not seen within %0d cycles", name, n);
    end
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{{5'd3, 5'd2, 5'd1, 5'd0}, 4'b0000, E_3210, 4'b1111};
    vecs[1] = '{{5'd19, 5'd18, 5'd17, 5'd16}, 4'b0100,
                {7'b1111110, 7'b0011000, 7'b1001000, 7'b1110001}, 4'b1011};
    vecs[2] = '{{5'd15, 5'd14, 5'd13, 5'd12}, 4'b1001,
                {7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001}, 4'b0110};
    vecs[3] = '{{5'd11, 5'd10, 5'd9, 5'd8}, 4'b0010,
                {7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000}, 4'b1101};
    vecs[4] = '{{5'd7, 5'd6, 5'd5, 5'd4}, 4'b1111, E_7654, 4'b0000};
    vecs[5] = '{{5'd31, 5'd25, 5'd20, 5'd19}, 4'b0001,
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111110}, 4'b1110};

    rst_n       = 1'b1;
    enable      = 1'b1;
    digit_codes = {5'd3, 5'd2, 5'd1, 5'd0};
    dp_in       = 4'b0000;
    blink_mask  = 4'b0001;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset", DARK);
    rst_n = 1'b1;

    // Frame 0 shows reset shadows (blank); blink phase toggles every two frames.
    check_range(1, FR, E_BLANK, 4'b1111, 4'b1111, "frame0_blank");
    check_range(1, FR, E_3210, 4'b1111, 4'b1111, "blink_f1");
    check_range(1, FR, E_3210, 4'b1111, 4'b1110, "blink_f2");
    check_range(1, FR, E_3210, 4'b1111, 4'b1110, "blink_f3");
    check_range(1, FR, E_3210, 4'b1111, 4'b1111, "blink_f4");

    blink_mask = 4'b0000;
    for (int v = 0; v < 6; v++) begin
      digit_codes = vecs[v].codes;
      dp_in       = vecs[v].dpi;
      wait_tick($sformatf("vec%0d_tick", v));
      check_range(1, FR, vecs[v].eseg, vecs[v].edp, 4'b1111, $sformatf("vec%0d", v));
    end

    // Mid-frame input change stays invisible until the next boundary.
    digit_codes = {5'd3, 5'd2, 5'd1, 5'd0};
    dp_in       = 4'b0000;
    wait_tick("tear_tick");
    check_range(1, 18, E_3210, 4'b1111, 4'b1111, "tear_pre");
    digit_codes = {5'd9, 5'd2, 5'd1, 5'd8};
    check_range(19, FR, E_3210, 4'b1111, 4'b1111, "tear_hold");
    check_range(1, FR, E_9218, 4'b1111, 4'b1111, "tear_new");

    // Disable mid-slot, change inputs while dark, then re-enable.
    check_range(1, 12, E_9218, 4'b1111, 4'b1111, "pre_dis");
    enable = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      check($sformatf("disabled k=%0d", k), DARK);
      if (k == 0) begin
        digit_codes = {5'd7, 5'd6, 5'd5, 5'd4};
        dp_in       = 4'b1111;
      end
    end
    enable = 1'b1;
    check_range(1, FR, E_7654, 4'b0000, 4'b1111, "reenable");

    // Asynchronous reset while a digit is lit.
    check_range(1, 13, E_7654, 4'b0000, 4'b1111, "pre_rst");
    rst_n = 1'b0;
    #1;
    check("async_reset", DARK);
    @(negedge clk);
    rst_n = 1'b1;
    check_range(1, FR, E_BLANK, 4'b1111, 4'b1111, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
